// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: runs a two-layer dense classifier (N_IN -> N_HID ReLU -> N_OUT)
// through a single shared MAC. It issues ROM addresses, accumulates products, keeps the
// hidden activations in an internal buffer and tracks the argmax of the output logits.
module nn_layer_sequencer #(
  parameter int N_IN   = 784,
  parameter int N_HID  = 32,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 42,
  parameter int W_AW   = 16,
  parameter int X_AW   = 10,
  parameter int B_AW   = 6
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic [X_AW-1:0]          x_addr,
  input  logic signed [DATA_W-1:0] x_data,
  output logic [W_AW-1:0]          w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic [B_AW-1:0]          b_addr,
  input  logic signed [DATA_W-1:0] b_data,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               digit,
  output logic                     digit_valid
);

  localparam int STAGES = 1;  // ROM read latency seen by the MAC
  localparam int KMAX   = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int JMAX   = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int KW     = $clog2(KMAX + 1);
  localparam int JW     = $clog2(JMAX + 1);
  localparam int HW     = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int PW     = 2 * DATA_W;

  localparam logic [KW-1:0] K1_LAST = KW'(N_IN - 1);
  localparam logic [KW-1:0] K2_LAST = KW'(N_HID - 1);
  localparam logic [JW-1:0] J1_LAST = JW'(N_HID - 1);
  localparam logic [JW-1:0] J2_LAST = JW'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);

  typedef enum logic [2:0] {IDLE, L1_MAC, L1_WB, L2_MAC, L2_WB, DONE_S} state_t;

  state_t state, state_nx;

  logic [KW-1:0]             k;
  logic [JW-1:0]             j;
  logic [W_AW-1:0]           w_base;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  bias_q;
  logic signed [DATA_W-1:0]  hid_q;
  logic                      first_q;
  logic                      lay_q;
  logic [STAGES-1:0]         vld_sr;
  logic [STAGES:0]           vld_pipe;
  logic signed [ACC_W-1:0]   best;
  logic [JW-1:0]             best_idx;
  logic [DATA_W-1:0]         hid_mem [N_HID];

  logic                      is_mac, is_l2, is_wb, k_last, j_last;
  logic signed [DATA_W-1:0]  in_sel, bias_now;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   prod_ext, bias_sh, sum, r_val;
  logic [DATA_W-1:0]         relu_sat;

  // Decode of the current state and the end-of-row / end-of-layer conditions
  always_comb begin
    is_mac = (state == L1_MAC) || (state == L2_MAC);
    is_wb  = (state == L1_WB)  || (state == L2_WB);
    is_l2  = (state == L2_MAC) || (state == L2_WB);
    k_last = (k == (is_l2 ? K2_LAST : K1_LAST));
    j_last = (j == (is_l2 ? J2_LAST : J1_LAST));
  end

  // Valid pipe: bit 0 is the address-issue cycle, bit STAGES is the data-arrival cycle
  always_comb vld_pipe = {vld_sr, is_mac};

  // MAC datapath and write-back arithmetic (Q8.8 x Q8.8 -> Q.16, back to Q.8 on write-back)
  always_comb begin
    in_sel   = lay_q ? hid_q : x_data;
    prod     = w_data * in_sel;
    prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    bias_now = first_q ? b_data : bias_q;
    bias_sh  = {{(ACC_W-DATA_W-FRAC){bias_now[DATA_W-1]}}, bias_now, {FRAC{1'b0}}};
    sum      = acc + (vld_pipe[STAGES] ? prod_ext : '0) + bias_sh;
    r_val    = sum >>> FRAC;
    if (r_val[ACC_W-1])      relu_sat = '0;
    else if (r_val > SAT_MAX) relu_sat = DATA_W'(SAT_MAX);
    else                      relu_sat = r_val[DATA_W-1:0];
  end

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and combinational outputs; abort beats start and any running layer
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE_S);
    x_addr   = '0;
    w_addr   = '0;
    b_addr   = '0;
    if (is_mac) begin
      x_addr = X_AW'(k);
      w_addr = w_base + W_AW'(k);
      b_addr = is_l2 ? (B_AW'(N_HID) + B_AW'(j)) : B_AW'(j);
    end
    case (state)
      IDLE:    if (start && !abort) state_nx = L1_MAC;
      L1_MAC:  if (abort) state_nx = IDLE; else if (k_last) state_nx = L1_WB;
      L1_WB:   if (abort) state_nx = IDLE; else state_nx = j_last ? L2_MAC : L1_MAC;
      L2_MAC:  if (abort) state_nx = IDLE; else if (k_last) state_nx = L2_WB;
      L2_WB:   if (abort) state_nx = IDLE; else state_nx = j_last ? DONE_S : L2_MAC;
      DONE_S:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Counters, ROM base and the one-cycle-late MAC pipeline
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      k       <= '0;
      j       <= '0;
      w_base  <= '0;
      acc     <= '0;
      bias_q  <= '0;
      hid_q   <= '0;
      first_q <= 1'b0;
      lay_q   <= 1'b0;
      vld_sr  <= '0;
    end else begin
      vld_sr  <= vld_pipe[STAGES-1:0];
      first_q <= is_mac && (k == '0);
      lay_q   <= (state == L2_MAC);
      hid_q   <= DATA_W'(hid_mem[k[HW-1:0]]);
      if (vld_pipe[STAGES] && first_q) bias_q <= b_data;
      if (state == IDLE) begin
        k      <= '0;
        j      <= '0;
        w_base <= '0;
        acc    <= '0;
      end else if (is_mac) begin
        k <= k_last ? '0 : k + 1'b1;
        if (vld_pipe[STAGES]) acc <= acc + prod_ext;
      end else if (is_wb) begin
        k      <= '0;
        j      <= j_last ? '0 : j + 1'b1;
        w_base <= w_base + (is_l2 ? W_AW'(N_HID) : W_AW'(N_IN));
        acc    <= '0;
      end
    end
  end

  // Hidden buffer write and running argmax; ties keep the lowest index
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_HID; i++) hid_mem[i] <= '0;
      best     <= '0;
      best_idx <= '0;
    end else begin
      if (state == L1_WB) hid_mem[j[HW-1:0]] <= relu_sat;
      if (state == L2_WB && ((j == '0) || (r_val > best))) begin
        best     <= r_val;
        best_idx <= j;
      end
    end
  end

  // Result register: cleared when a new inference starts, loaded on completion
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      digit       <= '0;
      digit_valid <= 1'b0;
    end else if (state == IDLE && start && !abort) begin
      digit_valid <= 1'b0;
    end else if (state == DONE_S) begin
      digit       <= 4'(best_idx);
      digit_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench: a small instance (4-2-3) for functional corners and a default-sized
// instance for full-size latency, argmax and abort behaviour.
module tb_nn_layer_sequencer;

  logic clk;
  int   checks = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- small instance: N_IN=4, N_HID=2, N_OUT=3 ----------------
  logic        s_rst, s_start, s_abort, s_busy, s_done, s_dv;
  logic [9:0]  s_xa;
  logic [15:0] s_wa;
  logic [5:0]  s_ba;
  logic [15:0] s_x, s_w, s_b;
  logic [3:0]  s_digit;
  logic [15:0] sx_val, sw_l1, sw_l2, sb_l1;
  bit          sb_asc;

  nn_layer_sequencer #(.N_IN(4), .N_HID(2), .N_OUT(3)) u_small (
    .CLOCK_50(clk), .reset(s_rst), .start(s_start), .abort(s_abort),
    .x_addr(s_xa), .x_data(s_x), .w_addr(s_wa), .w_data(s_w),
    .b_addr(s_ba), .b_data(s_b), .busy(s_busy), .done(s_done),
    .digit(s_digit), .digit_valid(s_dv));

  function automatic logic [15:0] s_wrom(input logic [15:0] a);
    return (a < 16'd8) ? sw_l1 : sw_l2;
  endfunction

  function automatic logic [15:0] s_brom(input logic [5:0] a);
    logic [15:0] t;
    t = 16'(a - 6'd2);
    if (a < 6'd2) return sb_l1;
    return sb_asc ? (t << 8) : 16'h0000;
  endfunction

  always @(posedge clk) begin
    s_x <= sx_val;
    s_w <= s_wrom(s_wa);
    s_b <= s_brom(s_ba);
  end

  // ---------------- default instance ----------------
  logic        b_rst, b_start, b_abort, b_busy, b_done, b_dv;
  logic [9:0]  b_xa;
  logic [15:0] b_wa;
  logic [5:0]  b_ba;
  logic [15:0] b_x, b_w, b_b;
  logic [3:0]  b_digit;

  nn_layer_sequencer u_big (
    .CLOCK_50(clk), .reset(b_rst), .start(b_start), .abort(b_abort),
    .x_addr(b_xa), .x_data(b_x), .w_addr(b_wa), .w_data(b_w),
    .b_addr(b_ba), .b_data(b_b), .busy(b_busy), .done(b_done),
    .digit(b_digit), .digit_valid(b_dv));

  // L2 row 7 lives at 784*32 + 7*32 .. +31
  always @(posedge clk) begin
    b_x <= 16'h0100;
    b_w <= (b_wa >= 16'd25312 && b_wa < 16'd25344) ? 16'h0200 : 16'h0100;
    b_b <= 16'h0000;
  end

  // ---------------- run helpers (stimulus only) ----------------
  task automatic run_small(output int n_done, output int n_pulse);
    n_done = -1; n_pulse = 0;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (s_done) begin
        n_pulse++;
        if (n_done < 0) n_done = n;
      end
      if (n_done >= 0 && n > n_done + 3) break;
      @(negedge clk);
    end
  endtask

  task automatic run_big(input bit pulse, output int n_done, output int n_pulse);
    n_done = -1; n_pulse = 0;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    for (int n = 1; n <= 26000; n++) begin
      b_start = pulse && (n == 100 || n == 1000);
      if (b_done) begin
        n_pulse++;
        if (n_done < 0) n_done = n;
      end
      if (n_done >= 0 && n > n_done + 3) break;
      @(negedge clk);
    end
    b_start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    s_rst = 1'b1; b_rst = 1'b1; s_start = 1'b1; b_start = 1'b1;
    s_abort = 1'b0; b_abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
    checks++; if (s_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", s_done); end
    checks++; if (s_digit !== 4'd0) begin failures++; $display("FAIL reset_digit got=%0d exp=0", s_digit); end
    checks++; if (s_dv !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", s_dv); end
    checks++; if ({s_xa, s_wa, s_ba} !== 32'd0) begin failures++; $display("FAIL reset_addr got x=%0d w=%0d b=%0d exp=0", s_xa, s_wa, s_ba); end
    checks++; if ({b_busy, b_done, b_dv, b_digit} !== 7'd0) begin failures++; $display("FAIL reset_big got=%b exp=0", {b_busy, b_done, b_dv, b_digit}); end
    s_rst = 1'b0; b_rst = 1'b0; s_start = 1'b0; b_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({s_busy, b_busy} !== 2'b00) begin failures++; $display("FAIL release_no_start got=%b exp=00", {s_busy, b_busy}); end
  endtask

  task automatic test_small_basic;
    int nd, np;
    sx_val = 16'h0100; sw_l1 = 16'h0100; sw_l2 = 16'h0100; sb_l1 = 16'h0000; sb_asc = 0;
    run_small(nd, np);
    checks++; if (nd !== 20) begin failures++; $display("FAIL small_latency got=%0d exp=20", nd); end
    checks++; if (np !== 1) begin failures++; $display("FAIL small_done_pulses got=%0d exp=1", np); end
    checks++; if (u_small.hid_mem[0] !== 16'h0400) begin failures++; $display("FAIL small_hid0 got=%h exp=0400", u_small.hid_mem[0]); end
    checks++; if (u_small.hid_mem[1] !== 16'h0400) begin failures++; $display("FAIL small_hid1 got=%h exp=0400", u_small.hid_mem[1]); end
    checks++; if (s_digit !== 4'd0) begin failures++; $display("FAIL small_tie_digit got=%0d exp=0", s_digit); end
    checks++; if (s_dv !== 1'b1) begin failures++; $display("FAIL small_dv got=%b exp=1", s_dv); end
    checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL small_idle got=%b exp=0", s_busy); end
  endtask

  task automatic test_relu_bias;
    int nd, np;
    sx_val = 16'h0100; sw_l1 = 16'h0100; sw_l2 = 16'h0100; sb_l1 = 16'hF600; sb_asc = 1;
    run_small(nd, np);
    checks++; if (nd !== 20) begin failures++; $display("FAIL relu_latency got=%0d exp=20", nd); end
    checks++; if ({u_small.hid_mem[0], u_small.hid_mem[1]} !== 32'd0) begin failures++; $display("FAIL relu_hidden got=%h %h exp=0", u_small.hid_mem[0], u_small.hid_mem[1]); end
    checks++; if (s_digit !== 4'd2) begin failures++; $display("FAIL bias_digit got=%0d exp=2", s_digit); end
  endtask

  task automatic test_saturation;
    int nd, np;
    sx_val = 16'h7F00; sw_l1 = 16'h7F00; sw_l2 = 16'h7F00; sb_l1 = 16'h0000; sb_asc = 1;
    run_small(nd, np);
    checks++; if (u_small.hid_mem[0] !== 16'h7FFF) begin failures++; $display("FAIL sat_hid0 got=%h exp=7fff", u_small.hid_mem[0]); end
    checks++; if (u_small.hid_mem[1] !== 16'h7FFF) begin failures++; $display("FAIL sat_hid1 got=%h exp=7fff", u_small.hid_mem[1]); end
    checks++; if (s_digit !== 4'd2) begin failures++; $display("FAIL sat_digit got=%0d exp=2", s_digit); end
  endtask

  task automatic test_default_digit;
    int nd, np;
    run_big(1'b0, nd, np);
    checks++; if (nd !== 25451) begin failures++; $display("FAIL big_latency got=%0d exp=25451", nd); end
    checks++; if (b_digit !== 4'd7) begin failures++; $display("FAIL big_digit got=%0d exp=7", b_digit); end
    checks++; if (b_dv !== 1'b1) begin failures++; $display("FAIL big_dv got=%b exp=1", b_dv); end
  endtask

  task automatic test_abort_restart;
    int nd, np, seen;
    seen = 0;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    for (int n = 1; n < 500; n++) begin
      if (b_done) seen++;
      @(negedge clk);
    end
    checks++; if (b_dv !== 1'b0) begin failures++; $display("FAIL run_dv_cleared got=%b exp=0", b_dv); end
    b_abort = 1'b1;
    @(negedge clk); b_abort = 1'b0;
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", b_busy); end
    repeat (5) begin
      if (b_done) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    checks++; if (b_dv !== 1'b0) begin failures++; $display("FAIL abort_dv got=%b exp=0", b_dv); end
    b_abort = 1'b1; b_start = 1'b1;
    @(negedge clk); b_abort = 1'b0; b_start = 1'b0;
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL abort_beats_start got=%b exp=0", b_busy); end
    run_big(1'b1, nd, np);
    checks++; if (nd !== 25451) begin failures++; $display("FAIL restart_latency got=%0d exp=25451", nd); end
    checks++; if (np !== 1) begin failures++; $display("FAIL restart_pulses got=%0d exp=1", np); end
    checks++; if (b_digit !== 4'd7) begin failures++; $display("FAIL restart_digit got=%0d exp=7", b_digit); end
  endtask

  task automatic test_reset_in_l2;
    int nd, np, seen;
    seen = 0;
    sx_val = 16'h0100; sw_l1 = 16'h0100; sw_l2 = 16'h0100; sb_l1 = 16'h0000; sb_asc = 0;
    run_small(nd, np);
    checks++; if (s_dv !== 1'b1) begin failures++; $display("FAIL pre_reset_dv got=%b exp=1", s_dv); end
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    repeat (12) @(negedge clk);
    s_rst = 1'b1;
    #1;
    checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL async_busy got=%b exp=0", s_busy); end
    checks++; if (s_dv !== 1'b0) begin failures++; $display("FAIL async_dv got=%b exp=0", s_dv); end
    @(negedge clk); s_rst = 1'b0;
    repeat (30) begin
      if (s_done || s_busy) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL post_reset_quiet got=%0d exp=0", seen); end
  endtask

  initial begin
    sx_val = 16'h0; sw_l1 = 16'h0; sw_l2 = 16'h0; sb_l1 = 16'h0; sb_asc = 0;
    test_reset();
    test_small_basic();
    test_relu_bias();
    test_saturation();
    test_default_digit();
    test_abort_restart();
    test_reset_in_l2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
